// File: rtl/reset_sequencer.sv
// Staged reset release for several downstream domains, with software/watchdog
// request handling, reset-cause capture and a saturating request counter.
module reset_sequencer #(
   parameter int NUM_DOMAINS = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   sw_rst_req_i,
   input  logic                   wdt_rst_req_i,
   output logic [NUM_DOMAINS-1:0] rstn_o,
   output logic                   busy_o,
   output logic [1:0]             cause_o,
   output logic [7:0]             reset_cnt_o
);

   localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int IW   = $clog2(NUM_DOMAINS + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_RELEASE = 2'd1,
      S_RUN     = 2'd2
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [CW-1:0]          r_cnt, w_cnt_nxt;
   logic [IW-1:0]          r_idx, w_idx_nxt;
   logic [NUM_DOMAINS-1:0] r_rstn, w_rstn_nxt;
   logic                   r_busy, w_busy_nxt;
   logic [1:0]             r_cause, w_cause_nxt;
   logic [7:0]             r_rcnt, w_rcnt_nxt;
   logic                   w_req;

   assign w_req = sw_rst_req_i | wdt_rst_req_i;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_rstn_nxt  = r_rstn;
      w_cause_nxt = r_cause;
      w_rcnt_nxt  = r_rcnt;

      if (w_req) begin
         // A request restarts the whole sequence from any state.
         w_state_nxt = S_HOLD;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
         w_rstn_nxt  = '0;
         w_cause_nxt = wdt_rst_req_i ? 2'b10 : 2'b01;
         w_rcnt_nxt  = (r_rcnt == 8'hFF) ? r_rcnt : r_rcnt + 8'd1;
      end else begin
         case (r_state)
            S_HOLD: begin
               w_rstn_nxt = '0;
               if (r_cnt == HOLD_LAST) begin
                  w_rstn_nxt[0] = 1'b1;
                  w_idx_nxt     = IDX_ONE;
                  w_cnt_nxt     = '0;
                  w_state_nxt   = (NUM_DOMAINS == 1) ? S_RUN : S_RELEASE;
               end else begin
                  w_cnt_nxt = CW'(r_cnt + 1'b1);
               end
            end
            S_RELEASE: begin
               if (r_cnt == GAP_LAST) begin
                  for (int i = 0; i < NUM_DOMAINS; i++) begin
                     if (IW'(i) == r_idx) w_rstn_nxt[i] = 1'b1;
                  end
                  w_idx_nxt = IW'(r_idx + 1'b1);
                  w_cnt_nxt = '0;
                  if (r_idx == IDX_LAST) w_state_nxt = S_RUN;
               end else begin
                  w_cnt_nxt = CW'(r_cnt + 1'b1);
               end
            end
            S_RUN: begin
               w_rstn_nxt = '1;
            end
            default: begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_rstn_nxt  = '0;
            end
         endcase
      end
   end

   // busy is registered alongside rstn so both change on the same edge.
   assign w_busy_nxt = ~&w_rstn_nxt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_HOLD;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_rstn  <= '0;
         r_busy  <= 1'b1;
         r_cause <= 2'b00;
         r_rcnt  <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_rstn  <= w_rstn_nxt;
         r_busy  <= w_busy_nxt;
         r_cause <= w_cause_nxt;
         r_rcnt  <= w_rcnt_nxt;
      end
   end

   assign rstn_o      = r_rstn;
   assign busy_o      = r_busy;
   assign cause_o     = r_cause;
   assign reset_cnt_o = r_rcnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus two parameter corners.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       sw = 1'b0;
   logic       wdt = 1'b0;

   logic [2:0] rstn_a;
   logic       busy_a;
   logic [1:0] cause_a;
   logic [7:0] cnt_a;

   logic [0:0] rstn_b;
   logic       busy_b;
   logic [1:0] cause_b;
   logic [7:0] cnt_b;

   logic [2:0] rstn_c;
   logic       busy_c;
   logic [1:0] cause_c;
   logic [7:0] cnt_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reset_sequencer #(.NUM_DOMAINS(3), .HOLD_CYCLES(16), .STAGE_GAP(4)) u_a (
      .clk_i(clk), .rst_i(rst_i), .sw_rst_req_i(sw), .wdt_rst_req_i(wdt),
      .rstn_o(rstn_a), .busy_o(busy_a), .cause_o(cause_a), .reset_cnt_o(cnt_a));

   reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_GAP(4)) u_b (
      .clk_i(clk), .rst_i(rst_i), .sw_rst_req_i(sw), .wdt_rst_req_i(wdt),
      .rstn_o(rstn_b), .busy_o(busy_b), .cause_o(cause_b), .reset_cnt_o(cnt_b));

   reset_sequencer #(.NUM_DOMAINS(3), .HOLD_CYCLES(2), .STAGE_GAP(1)) u_c (
      .clk_i(clk), .rst_i(rst_i), .sw_rst_req_i(sw), .wdt_rst_req_i(wdt),
      .rstn_o(rstn_c), .busy_o(busy_c), .cause_o(cause_c), .reset_cnt_o(cnt_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Default instance: releases at E0+16/20/24.
   function automatic logic [2:0] exp_a(input int k);
      return {k >= 24, k >= 20, k >= 16};
   endfunction

   // Runs edges E0+1..E0+24 checking the default instance's release pattern.
   task automatic release_check(input string tag);
      for (int k = 1; k <= 24; k++) begin
         tick();
         chk({tag, "_rstn"}, 32'(rstn_a), 32'(exp_a(k)));
         chk({tag, "_busy"}, 32'(busy_a), 32'(k < 24));
      end
   endtask

   initial begin
      // Power-on: rst_i high for 5 edges, last one is E0.
      repeat (5) tick();
      chk("por_rstn0", 32'(rstn_a), 32'h0);
      chk("por_busy0", 32'(busy_a), 32'h1);
      chk("por_cause", 32'(cause_a), 32'h0);
      chk("por_cnt", 32'(cnt_a), 32'h0);
      chk("b_rstn0", 32'(rstn_b), 32'h0);
      chk("c_rstn0", 32'(rstn_c), 32'h0);
      rst_i = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         tick();
         chk("por_rstn", 32'(rstn_a), 32'(exp_a(k)));
         chk("por_busy", 32'(busy_a), 32'(k < 24));
         if (k == 1) begin
            chk("b_rstn1", 32'(rstn_b), 32'h1);
            chk("b_busy1", 32'(busy_b), 32'h0);
         end
         if (k <= 4) begin
            chk("c_rstn", 32'(rstn_c), 32'({k >= 4, k >= 3, k >= 2}));
            chk("c_busy", 32'(busy_c), 32'(k < 4));
         end
      end
      chk("por_cause_end", 32'(cause_a), 32'h0);
      chk("por_cnt_end", 32'(cnt_a), 32'h0);

      // Stays in RUN with no request.
      repeat (3) tick();
      chk("run_rstn", 32'(rstn_a), 32'h7);
      chk("run_busy", 32'(busy_a), 32'h0);

      // Software pulse in RUN.
      sw = 1'b1;
      tick();
      sw = 1'b0;
      chk("sw_rstn", 32'(rstn_a), 32'h0);
      chk("sw_busy", 32'(busy_a), 32'h1);
      chk("sw_cause", 32'(cause_a), 32'h1);
      chk("sw_cnt", 32'(cnt_a), 32'h1);
      release_check("sw");

      // Watchdog aborts mid-RELEASE at E0+18.
      sw = 1'b1;
      tick();
      sw = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         tick();
         chk("ab_pre_rstn", 32'(rstn_a), 32'(exp_a(k)));
      end
      wdt = 1'b1;
      tick();
      wdt = 1'b0;
      chk("ab_rstn", 32'(rstn_a), 32'h0);
      chk("ab_cause", 32'(cause_a), 32'h2);
      chk("ab_cnt", 32'(cnt_a), 32'h3);
      release_check("ab");

      // sw and wdt together: watchdog wins.
      sw = 1'b1;
      wdt = 1'b1;
      tick();
      sw = 1'b0;
      wdt = 1'b0;
      chk("both_cause", 32'(cause_a), 32'h2);
      chk("both_cnt", 32'(cnt_a), 32'h4);
      release_check("both");

      // rst_i plus sw: power-on wins, count cleared.
      rst_i = 1'b1;
      sw = 1'b1;
      tick();
      rst_i = 1'b0;
      sw = 1'b0;
      chk("rs_cause", 32'(cause_a), 32'h0);
      chk("rs_cnt", 32'(cnt_a), 32'h0);
      chk("rs_rstn", 32'(rstn_a), 32'h0);
      release_check("rs");

      // Level request held 3 edges counts each edge; release restarts from the last.
      sw = 1'b1;
      repeat (3) tick();
      sw = 1'b0;
      chk("lvl_cnt", 32'(cnt_a), 32'h3);
      chk("lvl_cause", 32'(cause_a), 32'h1);
      chk("lvl_rstn", 32'(rstn_a), 32'h0);
      release_check("lvl");

      // Saturation: 300 pulses each followed by a full release.
      for (int i = 1; i <= 300; i++) begin
         sw = 1'b1;
         tick();
         sw = 1'b0;
         chk("sat_cnt", 32'(cnt_a), (i + 3 > 255) ? 32'd255 : 32'(i + 3));
         repeat (24) tick();
      end
      chk("sat_rstn", 32'(rstn_a), 32'h7);
      chk("sat_busy", 32'(busy_a), 32'h0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("sat_clr", 32'(cnt_a), 32'h0);
      chk("sat_clr_rstn", 32'(rstn_a), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Generates ordered, staged reset releases for several downstream domains from one synchronized system reset plus software and watchdog reset requests. Sits in the system clock domain, downstream of the board-level reset synchronizer. Each `rstn_o` bit feeds the reset synchronizer of its target domain. Records the cause of the most recent reset and counts request-initiated resets.

## Interface
- `NUM_DOMAINS`, default 3: number of staged reset outputs, legal 1..16.
- `HOLD_CYCLES`, default 16: cycles all outputs stay asserted after the reset source goes away, legal ≥1.
- `STAGE_GAP`, default 4: cycles between consecutive domain releases, legal ≥1.
- `clk_i`  input  1: the only clock; every flop is posedge `clk_i`.
- `rst_i`  input  1: reset, synchronous and active-high, already synchronized to `clk_i`.
- `sw_rst_req_i`  input  1: software reset request, sampled every edge, level or pulse.
- `wdt_rst_req_i`  input  1: watchdog reset request, sampled every edge, level or pulse.
- `rstn_o`  output  NUM_DOMAINS: active-low domain resets, registered; bit 0 is released first.
- `busy_o`  output  1: high while any `rstn_o` bit is low, registered.
- `cause_o`  output  2: cause of the latest reset; 00 power-on (`rst_i`), 01 software, 10 watchdog, 11 unused.
- `reset_cnt_o`  output  8: number of request-initiated resets, saturating at 255.

## Operation
- FSM states: HOLD, RELEASE, RUN.
- One counter `cnt` has width clog2(max(HOLD_CYCLES, STAGE_GAP)+1). One stage index `idx` has width clog2(NUM_DOMAINS+1).
- `rst_i` high at an edge sets:
  - state = HOLD, `cnt` = 0, `idx` = 0
  - `rstn_o` = all 0, `busy_o` = 1
  - `cause_o` = 00, `reset_cnt_o` = 0
- HOLD:
  - All `rstn_o` bits are 0. `cnt` increments each edge.
  - When `cnt` == HOLD_CYCLES-1, the next edge sets `rstn_o[0]` = 1, `idx` = 1, `cnt` = 0, and moves to RELEASE.
  - If NUM_DOMAINS == 1, that edge goes to RUN instead.
- RELEASE:
  - `cnt` increments each edge.
  - When `cnt` == STAGE_GAP-1, the next edge sets `rstn_o[idx]` = 1, increments `idx`, and clears `cnt`.
  - After `rstn_o[NUM_DOMAINS-1]` is set, the state moves to RUN.
- RUN: all `rstn_o` bits are 1 and `busy_o` = 0. The block waits for a request.
- Request handling:
  - A request is `sw_rst_req_i` or `wdt_rst_req_i` high at an edge while `rst_i` is low.
  - It is accepted in any state, including mid-HOLD and mid-RELEASE.
  - On the same edge: state = HOLD, `cnt` = 0, `idx` = 0, `rstn_o` = all 0, `busy_o` = 1.
- `cause_o` on an accepted request:
  - Set to 10 if `wdt_rst_req_i` is high, otherwise 01. Watchdog wins when both are high.
  - `cause_o` holds until the next reset or request.
- `reset_cnt_o`:
  - Increments by 1 per accepted-request edge, saturating at 255.
  - A held level request during HOLD counts on every edge, so software must pulse requests.
- `rst_i` has priority over requests on the same edge.
- `busy_o` == ~&`rstn_o` at all times, with both computed from the registered state.

## Timing
- Let E0 be the last edge at which `rst_i` or a request was sampled high.
- `rstn_o[k]` rises at edge E0 + HOLD_CYCLES + k·STAGE_GAP.
- `busy_o` falls on the same edge as `rstn_o[NUM_DOMAINS-1]` rises.
- With defaults, releases occur at E0+16, E0+20, E0+24, and `busy_o` falls at E0+24.
- Request-to-assert latency is 1 edge: the sampling edge itself drives `rstn_o` low.
- A request continuously high keeps the block in HOLD with `cnt` = 0. Release timing restarts from the last high sample.
- Output glitches are not permitted. All outputs are flop outputs.

## Test plan
- Power-on:
  - Stimulus: hold `rst_i` 5 cycles, then drop it.
  - Required: `rstn_o` = 000 through E0+15; 001 at E0+16, 011 at E0+20, 111 at E0+24; `busy_o` 1→0 at E0+24; `cause_o` = 00; `reset_cnt_o` = 0.
- Software reset in RUN:
  - Stimulus: 1-cycle `sw_rst_req_i`.
  - Required: `rstn_o` = 000 on the next edge; releases at +16/+20/+24; `cause_o` = 01; `reset_cnt_o` = 1.
- Abort mid-RELEASE:
  - Stimulus: `wdt_rst_req_i` pulse at E0+18, while `rstn_o` = 001.
  - Required: `rstn_o` = 000 at E0+18; new releases at E0+34/38/42; `cause_o` = 10.
- Simultaneous events:
  - Stimulus 1: sw and wdt high on the same edge. Required: `cause_o` = 10, `reset_cnt_o` +1.
  - Stimulus 2: `rst_i` plus sw on the same edge. Required: `cause_o` = 00, count cleared.
- Saturation:
  - Stimulus: 300 single-cycle requests, each followed by a full release.
  - Required: `reset_cnt_o` stops at 255; `rst_i` clears it to 0.
- Parameter corners:
  - Stimulus 1: NUM_DOMAINS=1, HOLD_CYCLES=1. Required: `rstn_o` high at E0+1.
  - Stimulus 2: STAGE_GAP=1. Required: consecutive bits release on consecutive edges.
